// File: rtl/axil_arbiter_rr_wr.sv
// axil_arbiter_rr_wr: round-robin write-channel arbiter for one AXI-Lite slave.
// Locks the grant from selection until the slave's B handshake completes.
// Ports: aclk, areset (async, active-high); request_wr[N] per-master requests;
//   aw_hs/w_hs/b_hs slave-side handshakes; grant_wr/grant_valid crossbar select;
//   timeout one-cycle pulse when the watchdog forces a release.
// Optional: define AXIL_ARB_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog;
//   without it timeout is tied to 0 and the grant is held until b_hs.
module axil_arbiter_rr_wr #(
    parameter int NUMBER_MASTER  = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [NUMBER_MASTER-1:0]         request_wr,
    input  logic                             aw_hs,
    input  logic                             w_hs,
    input  logic                             b_hs,
    output logic [$clog2(NUMBER_MASTER)-1:0] grant_wr,
    output logic                             grant_valid,
    output logic                             timeout
);

    localparam int GW = $clog2(NUMBER_MASTER);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RESP
    } state_t;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic          aw_done;
    logic          w_done;
    logic [GW-1:0] sel;
    logic [GW-1:0] next_ptr;
    logic          resp_done;
    logic          expire;
    logic          release_grant;
    int            scan_idx;

    // Scan from the highest offset down so the lowest offset from rr_ptr
    // with a pending request is the one left in sel.
    always_comb begin
        sel      = '0;
        scan_idx = 0;
        for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NUMBER_MASTER) begin
                scan_idx = scan_idx - NUMBER_MASTER;
            end
            if (request_wr[scan_idx]) begin
                sel = GW'(scan_idx);
            end
        end
    end

    // Explicit wrap keeps the pointer in range for non-power-of-two N.
    assign next_ptr = (grant_wr == GW'(NUMBER_MASTER - 1)) ? '0
                                                           : grant_wr + 1'b1;

    assign resp_done     = (state == RESP) && b_hs;
    assign release_grant = resp_done || expire;

`ifdef AXIL_ARB_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] watchdog;

    // Fires on the edge where the count would reach TIMEOUT_CYCLES.
    assign expire = (state != IDLE) &&
                    (watchdog == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            watchdog <= '0;
            timeout  <= 1'b0;
        end else begin
            // A B handshake coinciding with expiry is a normal completion.
            timeout <= expire && !resp_done;
            if (state == IDLE) begin
                watchdog <= '0;
            end else begin
                watchdog <= watchdog + 1'b1;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            grant_wr    <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else if (release_grant) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rr_ptr      <= next_ptr;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|request_wr) begin
                        grant_wr    <= sel;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
